// File: rtl/qkd_stream_sift_core.sv
// rtl/qkd_stream_sift_core.sv - streaming BB84 sifting core with QBER abort and key handoff.
// Define QBER_CHECK_EN to compare bob_bit against alice_bit and fail on excess errors.
module qkd_stream_sift_core #(
   parameter int KEY_W   = 128,
   parameter int MAX_RAW = 640,
   parameter int ERR_MAX = 8,
   parameter int CNT_W   = 10,
   parameter int ERR_W   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             alice_bit,
   input  logic             alice_base,
   input  logic             bob_base,
   input  logic             bob_bit,
   output logic [KEY_W-1:0] key,
   output logic             key_valid,
   input  logic             key_ack,
   output logic             busy,
   output logic             abort,
   output logic [CNT_W-1:0] raw_count,
   output logic [ERR_W-1:0] err_count
);

   typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DONE, S_FAIL} state_t;

   localparam logic [CNT_W-1:0] KEY_LIMIT = CNT_W'(KEY_W);
   localparam logic [CNT_W-1:0] RAW_LIMIT = CNT_W'(MAX_RAW);
   localparam logic [ERR_W-1:0] ERR_LIMIT = ERR_W'(ERR_MAX);

   state_t           state_q, state_d;
   logic [KEY_W-1:0] key_q, key_d;
   logic             key_valid_q, key_valid_d;
   logic             abort_q, abort_d;
   logic [CNT_W-1:0] raw_q, raw_d;
   logic [CNT_W-1:0] sift_q, sift_d;
   logic [ERR_W-1:0] err_q, err_d;

   logic beat;
   logic sift_hit;
   logic bit_err;

   assign beat     = in_valid && (state_q == S_COLLECT);
   assign sift_hit = (alice_base == bob_base);

`ifdef QBER_CHECK_EN
   assign bit_err = sift_hit && (alice_bit != bob_bit);
`else
   logic unused_bob_bit;
   assign unused_bob_bit = bob_bit;
   assign bit_err        = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      key_d       = key_q;
      key_valid_d = key_valid_q;
      abort_d     = abort_q;
      raw_d       = raw_q;
      sift_d      = sift_q;
      err_d       = err_q;
      case (state_q)
         S_IDLE, S_FAIL: begin
            if (start) begin
               state_d     = S_COLLECT;
               key_d       = '0;
               key_valid_d = 1'b0;
               abort_d     = 1'b0;
               raw_d       = '0;
               sift_d      = '0;
               err_d       = '0;
            end
         end
         S_COLLECT: begin
            if (beat) begin
               raw_d = raw_q + CNT_W'(1);
               if (sift_hit) begin
                  key_d  = {key_q[KEY_W-2:0], alice_bit};
                  sift_d = sift_q + CNT_W'(1);
               end
               if (bit_err) begin
                  err_d = err_q + ERR_W'(1);
               end
               // A full key wins over raw exhaustion landing on the same beat.
               if (err_d > ERR_LIMIT) begin
                  state_d = S_FAIL;
                  abort_d = 1'b1;
               end else if (sift_d == KEY_LIMIT) begin
                  state_d     = S_DONE;
                  key_valid_d = 1'b1;
               end else if (raw_d == RAW_LIMIT) begin
                  state_d = S_FAIL;
                  abort_d = 1'b1;
               end
            end
         end
         S_DONE: begin
            if (key_ack) begin
               state_d     = S_IDLE;
               key_valid_d = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         key_q       <= '0;
         key_valid_q <= 1'b0;
         abort_q     <= 1'b0;
         raw_q       <= '0;
         sift_q      <= '0;
         err_q       <= '0;
      end else begin
         state_q     <= state_d;
         key_q       <= key_d;
         key_valid_q <= key_valid_d;
         abort_q     <= abort_d;
         raw_q       <= raw_d;
         sift_q      <= sift_d;
         err_q       <= err_d;
      end
   end

   assign in_ready  = (state_q == S_COLLECT);
   assign busy      = (state_q == S_COLLECT);
   assign key       = key_q;
   assign key_valid = key_valid_q;
   assign abort     = abort_q;
   assign raw_count = raw_q;
   assign err_count = err_q;

endmodule

// File: tb/tb_qkd_stream_sift_core.sv
// tb/tb_qkd_stream_sift_core.sv - randomized self-checking bench for qkd_stream_sift_core.
module tb_qkd_stream_sift_core;
   localparam int KEY_W   = 8;
   localparam int MAX_RAW = 16;
   localparam int ERR_MAX = 1;
   localparam int CNT_W   = 5;
   localparam int ERR_W   = 4;
`ifdef QBER_CHECK_EN
   localparam bit QBER = 1'b1;
`else
   localparam bit QBER = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst, start, in_valid, key_ack;
   logic             alice_bit, alice_base, bob_base, bob_bit;
   logic             in_ready, key_valid, busy, abort;
   logic [KEY_W-1:0] key;
   logic [CNT_W-1:0] raw_count;
   logic [ERR_W-1:0] err_count;

   qkd_stream_sift_core #(.KEY_W(KEY_W), .MAX_RAW(MAX_RAW), .ERR_MAX(ERR_MAX),
                          .CNT_W(CNT_W), .ERR_W(ERR_W)) dut (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
      .alice_bit(alice_bit), .alice_base(alice_base), .bob_base(bob_base), .bob_bit(bob_bit),
      .key(key), .key_valid(key_valid), .key_ack(key_ack), .busy(busy), .abort(abort),
      .raw_count(raw_count), .err_count(err_count));

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: session flags, counters and the list of sifted bits in arrival order.
   bit m_collect, m_done, m_fail;
   int m_raw, m_err;
   bit sifted[$];

   function automatic int exp_key();
      int k = 0;
      foreach (sifted[i]) k = (k * 2 + int'(sifted[i])) % (1 << KEY_W);
      return k;
   endfunction

   function automatic logic [19:0] exp_vec();
      return {m_collect, m_done, m_fail, CNT_W'(m_raw), ERR_W'(m_err), KEY_W'(exp_key())};
   endfunction

   function automatic logic [19:0] obs_vec();
      return {in_ready, key_valid, abort, raw_count, err_count, key};
   endfunction

   task automatic model_clear();
      m_collect = 0; m_done = 0; m_fail = 0; m_raw = 0; m_err = 0;
      sifted.delete();
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
      if (!m_collect && !m_done) begin
         model_clear();
         m_collect = 1;
      end
   endtask

   task automatic pulse_ack();
      key_ack = 1'b1;
      tick();
      key_ack = 1'b0;
      if (m_done) m_done = 0;
   endtask

   task automatic do_beat(input bit v, input bit a, input bit ab, input bit bb, input bit bbit);
      in_valid = v; alice_bit = a; alice_base = ab; bob_base = bb; bob_bit = bbit;
      tick();
      in_valid = 1'b0;
      if (v && m_collect) begin
         m_raw++;
         if (ab == bb) begin
            sifted.push_back(a);
            if (QBER && a != bbit) m_err++;
         end
         if (QBER && m_err > ERR_MAX) begin
            m_collect = 0; m_fail = 1;
         end else if (sifted.size() == KEY_W) begin
            m_collect = 0; m_done = 1;
         end else if (m_raw == MAX_RAW) begin
            m_collect = 0; m_fail = 1;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      model_clear();
      n_tests++;
      if ({obs_vec(), busy} !== {20'h0, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_state got %h busy %b expected 00000 busy 0", obs_vec(), busy);
      end
      rst = 1'b0;
      for (int i = 0; i < 3; i++) do_beat(1, 1, 0, 0, 1);
      n_tests++;
      if (raw_count !== '0 || in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_ignores_valid got raw %0d ready %b expected raw 0 ready 0", raw_count, in_ready);
      end
   endtask

   task automatic test_full_key();
      bit pat[8] = '{1, 0, 1, 1, 0, 0, 1, 0};
      pulse_start();
      n_tests++;
      if (in_ready !== 1'b1 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL full_start_ready got ready %b busy %b expected 1 1", in_ready, busy);
      end
      for (int i = 0; i < 8; i++) begin
         bit b = $urandom_range(0, 1);
         do_beat(1, pat[i], b, b, pat[i]);
         n_tests++;
         if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL full_beat%0d got %h expected %h", i, obs_vec(), exp_vec());
         end
      end
      n_tests++;
      if (key !== 8'hB2 || key_valid !== 1'b1 || raw_count !== 5'd8 || err_count !== 4'd0) begin
         n_fail++;
         $display("FAIL full_key got key %h kv %b raw %0d err %0d expected b2 1 8 0", key, key_valid, raw_count, err_count);
      end
      for (int i = 0; i < 5; i++) begin
         do_beat(1, 1, 0, 0, 1);
         n_tests++;
         if (obs_vec() !== exp_vec() || key !== 8'hB2) begin
            n_fail++;
            $display("FAIL full_hold%0d got %h expected %h", i, obs_vec(), exp_vec());
         end
      end
      pulse_ack();
      n_tests++;
      if (key_valid !== 1'b0 || busy !== 1'b0 || key !== 8'hB2) begin
         n_fail++;
         $display("FAIL full_ack got kv %b busy %b key %h expected 0 0 b2", key_valid, busy, key);
      end
   endtask

   task automatic test_simultaneous_limit();
      pulse_start();
      for (int i = 0; i < MAX_RAW; i++) begin
         bit a = $urandom_range(0, 1);
         bit ab = $urandom_range(0, 1);
         bit bb = (i % 2 == 0) ? !ab : ab;
         do_beat(1, a, ab, bb, a);
      end
      n_tests++;
      if (obs_vec() !== exp_vec() || key_valid !== 1'b1 || abort !== 1'b0 || raw_count !== 5'd16) begin
         n_fail++;
         $display("FAIL simultaneous_limit got %h expected %h", obs_vec(), exp_vec());
      end
      pulse_ack();
   endtask

   task automatic test_raw_exhaust();
      pulse_start();
      for (int i = 0; i < MAX_RAW; i++) begin
         bit a = $urandom_range(0, 1);
         bit ab = $urandom_range(0, 1);
         bit bb = (i % 2 == 1 && i < 14) ? ab : !ab;
         do_beat(1, a, ab, bb, a);
      end
      n_tests++;
      if (obs_vec() !== exp_vec() || abort !== 1'b1 || in_ready !== 1'b0 || key_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL raw_exhaust got %h expected %h", obs_vec(), exp_vec());
      end
      pulse_ack();
      n_tests++;
      if (abort !== 1'b1 || raw_count !== 5'd16) begin
         n_fail++;
         $display("FAIL fail_ignores_ack got abort %b raw %0d expected 1 16", abort, raw_count);
      end
      pulse_start();
      n_tests++;
      if (raw_count !== '0 || err_count !== '0 || abort !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL fail_restart got raw %0d err %0d abort %b ready %b expected 0 0 0 1", raw_count, err_count, abort, in_ready);
      end
      for (int i = 0; i < KEY_W; i++) begin
         bit a = $urandom_range(0, 1);
         do_beat(1, a, 1, 1, a);
      end
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
         n_fail++;
         $display("FAIL restart_key got %h expected %h", obs_vec(), exp_vec());
      end
      pulse_ack();
   endtask

   task automatic test_qber();
      int i = 0;
      pulse_start();
      do_beat(1, 1, 0, 0, 1);
      do_beat(1, 0, 1, 1, 1);
      do_beat(1, 1, 0, 1, 1);
      do_beat(1, 1, 1, 1, 0);
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
         n_fail++;
         $display("FAIL qber_second_err got %h expected %h", obs_vec(), exp_vec());
      end
      if (QBER) begin
         n_tests++;
         if (abort !== 1'b1 || err_count !== 4'd2 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL qber_abort got abort %b err %0d ready %b expected 1 2 0", abort, err_count, in_ready);
         end
      end
      while (m_collect && i < MAX_RAW) begin
         bit a = $urandom_range(0, 1);
         do_beat(1, a, 0, 0, a);
         i++;
      end
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
         n_fail++;
         $display("FAIL qber_end got %h expected %h", obs_vec(), exp_vec());
      end
      if (m_done) pulse_ack();
   endtask

   task automatic test_reset_mid();
      pulse_start();
      for (int i = 0; i < 5; i++) do_beat(1, $urandom_range(0, 1), 0, 0, 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      model_clear();
      n_tests++;
      if (raw_count !== '0 || key !== '0 || in_ready !== 1'b0 || obs_vec() !== exp_vec()) begin
         n_fail++;
         $display("FAIL reset_mid got %h expected 00000", obs_vec());
      end
      pulse_start();
      for (int i = 0; i < KEY_W; i++) begin
         bit a = $urandom_range(0, 1);
         do_beat(1, a, 0, 0, a);
      end
      n_tests++;
      if (obs_vec() !== exp_vec() || key_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_mid_key got %h expected %h", obs_vec(), exp_vec());
      end
      pulse_ack();
   endtask

   task automatic test_random();
      for (int s = 0; s < 6; s++) begin
         int cyc = 0;
         pulse_start();
         while (m_collect && cyc < 60) begin
            bit v = ($urandom_range(0, 3) != 0);
            bit a = $urandom_range(0, 1);
            bit ab = $urandom_range(0, 1);
            bit bb = ($urandom_range(0, 3) == 0) ? !ab : ab;
            bit bbit = ($urandom_range(0, 7) == 0) ? !a : a;
            do_beat(v, a, ab, bb, bbit);
            cyc++;
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
               n_fail++;
               $display("FAIL random_s%0d_c%0d got %h expected %h", s, cyc, obs_vec(), exp_vec());
            end
         end
         n_tests++;
         if (m_collect) begin
            n_fail++;
            $display("FAIL random_timeout_s%0d got still collecting expected session end", s);
         end
         if (m_done) begin
            pulse_ack();
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
               n_fail++;
               $display("FAIL random_ack_s%0d got %h expected %h", s, obs_vec(), exp_vec());
            end
         end
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; in_valid = 1'b0; key_ack = 1'b0;
      alice_bit = 1'b0; alice_base = 1'b0; bob_base = 1'b0; bob_bit = 1'b0;
      model_clear();
      test_reset();
      test_full_key();
      test_simultaneous_limit();
      test_raw_exhaust();
      test_qber();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/qkd_stream_sift_core.md
Name: qkd_stream_sift_core

Overview:
- Streaming, parametrised successor to the fixed 640-sample batch QKD core.
- Accepts one BB84 measurement event per cycle over a valid/ready handshake.
- Sifts on-the-fly (keeps bits where Alice and Bob bases match) and assembles a KEY_W-bit key.
- Counts disagreements between Alice's and Bob's bits (QBER), aborts the session on raw-budget exhaustion or excess errors, and hands the key downstream with a valid/ack handshake.

Parameters:
- KEY_W, 128, sifted bits per final key (>=2).
- MAX_RAW, 640, raw events allowed per session before failure.
- ERR_MAX, 8, maximum tolerated bit disagreements among sifted bits.
- CNT_W, 10, width of raw/sift counters; must hold MAX_RAW.
- ERR_W, 8, width of the error counter.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin session; honoured in IDLE and FAIL only.
- in_valid  in  1  event present.
- in_ready  out  1  core accepts an event this cycle.
- alice_bit  in  1  Alice's raw bit.
- alice_base  in  1  Alice's encoding base.
- bob_base  in  1  Bob's measurement base.
- bob_bit  in  1  Bob's measured bit.
- key  out  KEY_W  assembled sifted key.
- key_valid  out  1  key complete and stable.
- key_ack  in  1  consumer has taken the key.
- busy  out  1  high in COLLECT.
- abort  out  1  session failed.
- raw_count  out  CNT_W  events accepted this session.
- err_count  out  ERR_W  sifted disagreements this session.

Behaviour:
- Reset (rst=1 at clock edge, any state): state=IDLE; key, key_valid, in_ready, busy, abort, raw_count, err_count and internal sift_count all 0. Reset mid-session discards all progress.
- in_ready = (state==COLLECT); busy = in_ready. Both are decoded from registered state only, with no combinational path from in_valid.
- Beat = in_valid && in_ready. Inputs while in_ready=0 are ignored.
- IDLE:
  - start=1: clear key, counters and abort; go to COLLECT next cycle.
- COLLECT, on each beat:
  - raw_count += 1.
  - If alice_base==bob_base: key <= {key[KEY_W-2:0], alice_bit}, so the first sifted bit ends at key[KEY_W-1]; sift_count += 1; if alice_bit!=bob_bit, err_count += 1.
  - Mismatched-base beats change only raw_count.
- COLLECT transitions, evaluated on the updated values, with priority err > done > raw:
  - err_count > ERR_MAX -> FAIL.
  - Else sift_count == KEY_W -> DONE. This holds even if raw_count == MAX_RAW on the same beat.
  - Else raw_count == MAX_RAW -> FAIL.
  - start is ignored in COLLECT.
- DONE:
  - key_valid=1 starting the cycle after the beat that delivers the KEY_W-th sifted bit (1-cycle latency).
  - key and counters are held stable.
  - key_ack=1 -> IDLE; key_valid=0 next cycle; key retains its value until the next start.
  - start is ignored in DONE.
- FAIL:
  - abort=1 (sticky); key_valid=0; key and counters are held for debug.
  - start=1 -> clear everything and go directly to COLLECT.
  - key_ack is ignored.
- Width rules: counters never wrap, because the transitions fire before overflow. CNT_W must be >= clog2(MAX_RAW+1) and ERR_W >= clog2(ERR_MAX+2).

Optional Feature:
QBER_CHECK_EN
- Defined: bob_bit is compared with alice_bit, err_count is maintained, and the err > ERR_MAX transition to FAIL is active.
- Undefined: bob_bit is ignored, err_count is tied to 0, and the only failure cause is raw exhaustion.

Test Plan:
1. Reset, with parameters KEY_W=8, MAX_RAW=16, ERR_MAX=1 (used for all scenarios): hold rst 2 cycles -> all outputs 0, in_ready=0. Drive in_valid=1 in IDLE -> raw_count remains 0.
2. Full key: start, then 8 matched-base beats with alice_bit=1,0,1,1,0,0,1,0 and bob_bit equal -> key_valid rises the cycle after beat 8, key=8'hB2, raw_count=8, err_count=0. Hold key_ack low 5 cycles -> key stable. Pulse key_ack -> IDLE, key_valid=0.
3. Simultaneous limit: 16 beats alternating mismatch/match (8 sifted bits) -> DONE, not FAIL; raw_count=16.
4. Raw exhaustion: 16 beats with only 7 matched bases -> abort=1, in_ready=0 after beat 16. start -> counters 0, abort=0, in_ready=1.
5. QBER: 2 sifted disagreements (ERR_MAX=1) -> with QBER_CHECK_EN, FAIL on the second error beat (err_count=2). Without the macro, the same stream completes normally with err_count=0.
6. Reset mid-session: rst asserted after 5 beats -> next cycle state IDLE, raw_count=0, key=0. A subsequent start and 8 clean beats yield a correct key.
